pipeline_stall_controller: RTL and testbench
============================================

# pipeline_stall_controller

Central stall/flush sequencer for the 5-stage pipeline. It takes the raw hazard conditions (load-use hazard flag, multi-cycle mul/div start, data-memory wait, taken branch) and arbitrates them by priority. It then drives every pipeline-register write enable and bubble/flush control from one place. It also sequences multi-cycle EX operations with an internal FSM and latency counter, and keeps a saturating stall-cycle statistic.

## Interface
- `MD_LAT`, default 4: total EX-stage cycles of a mul/div op; legal range 2..255.
- `STALL_CNT_W`, default 16: width of the stall statistic counter.

- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous, active-low reset
- `load_use_hz`  in  1  ID/EX is a load whose Rt matches IF/ID Rs or Rt
- `md_start`  in  1  EX-stage instruction is mul/div; held high while it occupies EX
- `mem_access`  in  1  MEM stage holds a load/store
- `dmem_ready`  in  1  data memory completes the access this cycle
- `branch_taken`  in  1  branch resolved taken in EX this cycle
- `pc_write`, `ifid_write`, `idex_write`, `exmem_write`  out  1 each  register write enables
- `ifid_flush`, `idex_bubble`, `exmem_bubble`, `memwb_bubble`  out  1 each  insert NOP into that register
- `md_busy`  out  1  EX is occupied by an incomplete mul/div
- `md_done`  out  1  single-cycle pulse: mul/div result advances to EX/MEM this cycle
- `stall_count`  out  STALL_CNT_W  saturating count of cycles with `pc_write`=0

## Operation
- The FSM is registered. States: RUN, MD_WAIT. There is an 8-bit down-counter `md_cnt`.
- Outputs are combinational from state, `md_cnt` and inputs (Mealy).
- Default outputs: all `*_write`=1; all flush/bubble signals, `md_busy` and `md_done`=0.
- Priority, highest first:
  1. **MEM freeze**, when `mem_access`=1 and `dmem_ready`=0, in any state.
     - Set `pc_write`, `ifid_write`, `idex_write`, `exmem_write` to 0 and `memwb_bubble`=1.
     - FSM state and `md_cnt` hold.
     - `md_done` is forced to 0.
     - All other requests are ignored.
  2. **MD stall**, in MD_WAIT with `md_cnt`≠0.
     - Set `pc_write`, `ifid_write`, `idex_write` to 0, `exmem_bubble`=1, `md_busy`=1.
     - Decrement `md_cnt`.
     - Ignore `branch_taken`, `load_use_hz` and `md_start`.
  3. **MD start**, in RUN with `md_start`=1.
     - Same outputs as MD stall.
     - Next state is MD_WAIT and `md_cnt` loads MD_LAT−2.
  4. **Branch flush**: `branch_taken`=1 gives `ifid_flush`=1 and `idex_bubble`=1. `pc_write` stays 1 so the target is loaded.
  5. **Load-use stall**: `load_use_hz`=1 gives `pc_write`=0, `ifid_write`=0, `idex_bubble`=1.
- Release cycle (MD_WAIT with `md_cnt`=0, no MEM freeze):
  - `md_done`=1 and next state is RUN.
  - `md_start` is masked for this cycle.
  - Branch and load-use requests are evaluated per rules 4–5.
- Branch and load-use in the same cycle: branch wins, and load-use is dropped because the dependent instruction is flushed.
- `stall_count` increments on every cycle where `pc_write`=0 and saturates at all-ones.

## Timing
- Reset (`rst_n`=0, asynchronous): state RUN, `md_cnt`=0, `stall_count`=0.
- With inputs at 0, during and after reset: all `*_write`=1, all bubbles, flushes, `md_busy` and `md_done`=0.
- Load-use: 1 stall cycle per assertion. The bubble occurs in the same cycle as the hazard.
- Branch: flush in the same cycle; 0 PC stall cycles.
- Mul/div started in cycle T:
  - Front-end stall lasts exactly MD_LAT−1 cycles (T..T+MD_LAT−2).
  - `md_done` pulses at T+MD_LAT−1 if no MEM freeze occurs.
  - Each MEM-freeze cycle extends the sequence by 1 cycle, with the counter frozen.
- A MEM freeze lasts exactly as long as `mem_access`=1 and `dmem_ready`=0, with no minimum.
- Reset asserted mid-MD_WAIT: the FSM is in RUN immediately; `md_busy` and `md_done` go to 0 asynchronously.
- A new `md_start` in the cycle after release starts a new full sequence (back-to-back ops).

## Test plan
- **Reset:** assert `rst_n`=0 mid-MD_WAIT (MD_LAT=4) → `md_busy`=0, `pc_write`=1, `stall_count`=0 asynchronously.
- **Load-use:** `load_use_hz` high for 1 cycle → `pc_write`=0, `ifid_write`=0, `idex_bubble`=1 for that cycle only; `stall_count` becomes 1.
- **Mul/div:** MD_LAT=4, `md_start` held at T..T+3 → `pc_write`=0 at T, T+1, T+2; `md_done`=1 at T+3 only; `stall_count`=3.
- **MEM freeze inside mul/div:** MD_LAT=4, `mem_access`=1 with `dmem_ready`=0 at T+1..T+2 → all writes 0 there, `memwb_bubble`=1; `md_done` moves to T+5.
- **Branch with load-use:** `branch_taken`=1 and `load_use_hz`=1 together → `ifid_flush`=1, `idex_bubble`=1, `pc_write`=1; `stall_count` unchanged.
- **Saturation:** STALL_CNT_W=4, 20 load-use cycles → `stall_count`=15 and holds.

Source files
------------

// File: rtl/pipeline_stall_controller.sv
// Central stall/flush sequencer for the 5-stage pipeline: hazard arbitration,
// multi-cycle mul/div sequencing and a saturating stall-cycle statistic.
//
// state   | meaning
// --------+----------------------------------------------------------------
// RUN     | normal flow; hazards arbitrated cycle by cycle
// MD_WAIT | mul/div occupying EX; md_cnt counts remaining stall cycles,
//         | md_cnt == 0 is the release cycle (md_done)
`timescale 1ns/1ps
module pipeline_stall_controller #(
   parameter int MD_LAT      = 4,
   parameter int STALL_CNT_W = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   load_use_hz,
   input  logic                   md_start,
   input  logic                   mem_access,
   input  logic                   dmem_ready,
   input  logic                   branch_taken,
   output logic                   pc_write,
   output logic                   ifid_write,
   output logic                   idex_write,
   output logic                   exmem_write,
   output logic                   ifid_flush,
   output logic                   idex_bubble,
   output logic                   exmem_bubble,
   output logic                   memwb_bubble,
   output logic                   md_busy,
   output logic                   md_done,
   output logic [STALL_CNT_W-1:0] stall_count
);

   typedef enum logic {
      RUN     = 1'b0,
      MD_WAIT = 1'b1
   } state_t;

   localparam logic [7:0] MD_CNT_INIT = 8'(MD_LAT - 2);

   state_t     state;
   state_t     state_nxt;
   logic [7:0] md_cnt;
   logic [7:0] md_cnt_nxt;
   logic       mem_freeze;

   assign mem_freeze = mem_access & ~dmem_ready;

   always_comb begin
      pc_write     = 1'b1;
      ifid_write   = 1'b1;
      idex_write   = 1'b1;
      exmem_write  = 1'b1;
      ifid_flush   = 1'b0;
      idex_bubble  = 1'b0;
      exmem_bubble = 1'b0;
      memwb_bubble = 1'b0;
      md_busy      = 1'b0;
      md_done      = 1'b0;
      state_nxt    = state;
      md_cnt_nxt   = md_cnt;

      if (mem_freeze) begin
         pc_write     = 1'b0;
         ifid_write   = 1'b0;
         idex_write   = 1'b0;
         exmem_write  = 1'b0;
         memwb_bubble = 1'b1;
      end else if (state == MD_WAIT && md_cnt != 8'd0) begin
         pc_write     = 1'b0;
         ifid_write   = 1'b0;
         idex_write   = 1'b0;
         exmem_bubble = 1'b1;
         md_busy      = 1'b1;
         md_cnt_nxt   = md_cnt - 8'd1;
      end else if (state == RUN && md_start) begin
         pc_write     = 1'b0;
         ifid_write   = 1'b0;
         idex_write   = 1'b0;
         exmem_bubble = 1'b1;
         md_busy      = 1'b1;
         state_nxt    = MD_WAIT;
         md_cnt_nxt   = MD_CNT_INIT;
      end else begin
         // release cycle masks md_start; the op still in EX is the one finishing
         if (state == MD_WAIT) begin
            md_done   = 1'b1;
            state_nxt = RUN;
         end
         if (branch_taken) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
         end else if (load_use_hz) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= RUN;
         md_cnt <= 8'd0;
      end else begin
         state  <= state_nxt;
         md_cnt <= md_cnt_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_count <= '0;
      end else if (!pc_write && stall_count != '1) begin
         stall_count <= stall_count + 1'b1;
      end
   end

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Self-checking bench: directed scenarios plus randomized traffic compared
// every cycle against a cycle-count model of the stall/flush rules.
`timescale 1ns/1ps
module tb_pipeline_stall_controller;

   localparam int MD_LAT  = 4;
   localparam int CNT_MAX = 65535;
   localparam int SAT_MAX = 15;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic load_use_hz = 1'b0, md_start = 1'b0, mem_access = 1'b0;
   logic dmem_ready = 1'b0, branch_taken = 1'b0;

   logic pc_write, ifid_write, idex_write, exmem_write;
   logic ifid_flush, idex_bubble, exmem_bubble, memwb_bubble, md_busy, md_done;
   logic [15:0] stall_count;

   logic s_pc_write, s_ifid_write, s_idex_write, s_exmem_write;
   logic s_ifid_flush, s_idex_bubble, s_exmem_bubble, s_memwb_bubble, s_md_busy, s_md_done;
   logic [3:0] s_stall_count;

   int n_cmp = 0;
   int n_err = 0;
   int cyc = 0;

   // model: md_left = cycles the current mul/div still occupies EX after this one
   int md_left = 0;
   int m_cnt = 0;
   int m_cnt_sat = 0;

   always #5 clk = ~clk;

   pipeline_stall_controller #(.MD_LAT(MD_LAT), .STALL_CNT_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .load_use_hz(load_use_hz), .md_start(md_start),
      .mem_access(mem_access), .dmem_ready(dmem_ready), .branch_taken(branch_taken),
      .pc_write(pc_write), .ifid_write(ifid_write), .idex_write(idex_write),
      .exmem_write(exmem_write), .ifid_flush(ifid_flush), .idex_bubble(idex_bubble),
      .exmem_bubble(exmem_bubble), .memwb_bubble(memwb_bubble), .md_busy(md_busy),
      .md_done(md_done), .stall_count(stall_count));

   pipeline_stall_controller #(.MD_LAT(MD_LAT), .STALL_CNT_W(4)) dut_sat (
      .clk(clk), .rst_n(rst_n), .load_use_hz(load_use_hz), .md_start(md_start),
      .mem_access(mem_access), .dmem_ready(dmem_ready), .branch_taken(branch_taken),
      .pc_write(s_pc_write), .ifid_write(s_ifid_write), .idex_write(s_idex_write),
      .exmem_write(s_exmem_write), .ifid_flush(s_ifid_flush), .idex_bubble(s_idex_bubble),
      .exmem_bubble(s_exmem_bubble), .memwb_bubble(s_memwb_bubble), .md_busy(s_md_busy),
      .md_done(s_md_done), .stall_count(s_stall_count));

   task automatic chk(input string nm, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s cycle %0d: got %0d expected %0d", nm, cyc, act, exp);
      end
   endtask

   task automatic model_reset();
      md_left = 0;
      m_cnt = 0;
      m_cnt_sat = 0;
   endtask

   task automatic step(input bit lu, input bit ms, input bit ma, input bit dr, input bit bt);
      bit fz;
      bit e_pc, e_ifid, e_idex, e_exmem, e_flush, e_idb, e_exb, e_mwb, e_busy, e_done;
      @(negedge clk);
      load_use_hz = lu; md_start = ms; mem_access = ma; dmem_ready = dr; branch_taken = bt;
      #2;
      fz = ma && !dr;
      e_pc = 1; e_ifid = 1; e_idex = 1; e_exmem = 1;
      e_flush = 0; e_idb = 0; e_exb = 0; e_mwb = 0; e_busy = 0; e_done = 0;
      if (fz) begin
         e_pc = 0; e_ifid = 0; e_idex = 0; e_exmem = 0; e_mwb = 1;
      end else if (md_left > 1 || (md_left == 0 && ms)) begin
         e_pc = 0; e_ifid = 0; e_idex = 0; e_exb = 1; e_busy = 1;
      end else begin
         e_done = (md_left == 1);
         if (bt) begin
            e_flush = 1; e_idb = 1;
         end else if (lu) begin
            e_pc = 0; e_ifid = 0; e_idb = 1;
         end
      end
      chk("pc_write", pc_write, e_pc);
      chk("ifid_write", ifid_write, e_ifid);
      chk("idex_write", idex_write, e_idex);
      chk("exmem_write", exmem_write, e_exmem);
      chk("ifid_flush", ifid_flush, e_flush);
      chk("idex_bubble", idex_bubble, e_idb);
      chk("exmem_bubble", exmem_bubble, e_exb);
      chk("memwb_bubble", memwb_bubble, e_mwb);
      if (!fz) chk("md_busy", md_busy, e_busy);
      chk("md_done", md_done, e_done);
      chk("stall_count", stall_count, m_cnt);
      chk("stall_count_sat", s_stall_count, m_cnt_sat);
      if (!fz) begin
         if (md_left > 0) md_left--;
         else if (ms) md_left = MD_LAT - 1;
      end
      if (!e_pc) begin
         if (m_cnt < CNT_MAX) m_cnt++;
         if (m_cnt_sat < SAT_MAX) m_cnt_sat++;
      end
      cyc++;
   endtask

   task automatic do_reset();
      @(negedge clk);
      load_use_hz = 0; md_start = 0; mem_access = 0; dmem_ready = 0; branch_taken = 0;
      rst_n = 0;
      model_reset();
      #2;
      chk("rst_pc_write", pc_write, 1);
      chk("rst_md_busy", md_busy, 0);
      chk("rst_stall_count", stall_count, 0);
      @(negedge clk);
      rst_n = 1;
   endtask

   initial begin
      bit ms_r;
      do_reset();
      chk("rst_idex_bubble", idex_bubble, 0);
      chk("rst_md_done", md_done, 0);

      // load-use: one stall cycle
      step(1, 0, 0, 0, 0);
      chk("lu_pc_write", pc_write, 0);
      chk("lu_ifid_write", ifid_write, 0);
      chk("lu_idex_bubble", idex_bubble, 1);
      step(0, 0, 0, 0, 0);
      chk("lu_after_pc_write", pc_write, 1);
      chk("lu_stall_count", stall_count, 1);

      // mul/div, MD_LAT=4
      do_reset();
      for (int i = 0; i < 3; i++) begin
         step(0, 1, 0, 0, 0);
         chk("md_pc_write", pc_write, 0);
         chk("md_done_early", md_done, 0);
      end
      step(0, 1, 0, 0, 0);
      chk("md_done_T3", md_done, 1);
      chk("md_pc_write_T3", pc_write, 1);
      step(0, 0, 0, 0, 0);
      chk("md_done_T4", md_done, 0);
      chk("md_stall_count", stall_count, 3);

      // MEM freeze inside mul/div at T+1..T+2
      do_reset();
      step(0, 1, 0, 0, 0);
      for (int i = 0; i < 2; i++) begin
         step(0, 1, 1, 0, 0);
         chk("fz_pc_write", pc_write, 0);
         chk("fz_exmem_write", exmem_write, 0);
         chk("fz_memwb_bubble", memwb_bubble, 1);
      end
      step(0, 1, 0, 0, 0);
      chk("fz_done_T3", md_done, 0);
      step(0, 1, 0, 0, 0);
      chk("fz_done_T4", md_done, 0);
      step(0, 1, 0, 0, 0);
      chk("fz_done_T5", md_done, 1);

      // back-to-back mul/div right after release
      step(0, 1, 0, 0, 0);
      chk("b2b_md_busy", md_busy, 1);
      chk("b2b_done", md_done, 0);
      for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0);
      chk("b2b_done_end", md_done, 1);

      // branch beats load-use
      do_reset();
      step(1, 0, 0, 0, 1);
      chk("br_flush", ifid_flush, 1);
      chk("br_idex_bubble", idex_bubble, 1);
      chk("br_pc_write", pc_write, 1);
      step(0, 0, 0, 0, 0);
      chk("br_stall_count", stall_count, 0);

      // saturation of the 4-bit statistic
      do_reset();
      for (int i = 0; i < 20; i++) step(1, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0);
      chk("sat_count_w4", s_stall_count, 15);
      chk("sat_count_w16", stall_count, 20);
      step(1, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0);
      chk("sat_hold_w4", s_stall_count, 15);

      // asynchronous reset mid-MD_WAIT
      do_reset();
      step(0, 1, 0, 0, 0);
      step(0, 1, 0, 0, 0);
      @(posedge clk);
      #1;
      load_use_hz = 0; md_start = 0; mem_access = 0; dmem_ready = 0; branch_taken = 0;
      #1;
      chk("arst_busy_before", md_busy, 1);
      rst_n = 0;
      #1;
      chk("arst_md_busy", md_busy, 0);
      chk("arst_md_done", md_done, 0);
      chk("arst_pc_write", pc_write, 1);
      chk("arst_stall_count", stall_count, 0);
      model_reset();
      @(negedge clk);
      rst_n = 1;

      // randomized traffic; md_start held while the model says EX is occupied
      for (int i = 0; i < 3000; i++) begin
         ms_r = (md_left > 0) ? 1'b1 : ($urandom_range(0, 7) == 0);
         step($urandom_range(0, 4) == 0, ms_r, $urandom_range(0, 9) < 3,
              $urandom_range(0, 1) == 1, $urandom_range(0, 4) == 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
